// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bundle and width helper for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  // Number of bits needed to index 'value' positions (shift-amount width for XLEN).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I ALU datapath: result plus zero/neg/carry/ovf/illegal flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  output logic [XLEN-1:0] o_result,
  output alu_flags_t      o_flags
);

  localparam int unsigned SHW = clog2(XLEN);
  localparam int unsigned MSB = XLEN - 1;

  logic [SHW-1:0] w_shamt;
  logic [XLEN:0]  w_add;
  logic [XLEN:0]  w_sub;
  logic           w_add_ovf;
  logic           w_sub_ovf;
  logic           w_lt_s;
  logic           w_lt_u;

  assign w_shamt   = i_b[SHW-1:0];
  assign w_add     = {1'b0, i_a} + {1'b0, i_b};
  // Subtract as A + ~B + 1 so bit XLEN is the NOT-borrow carry.
  assign w_sub     = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, 1'b1};
  assign w_add_ovf = (i_a[MSB] == i_b[MSB]) && (w_add[MSB] != i_a[MSB]);
  assign w_sub_ovf = (i_a[MSB] != i_b[MSB]) && (w_sub[MSB] != i_a[MSB]);
  assign w_lt_s    = w_sub[MSB] ^ w_sub_ovf;
  assign w_lt_u    = ~w_sub[XLEN];

  // Operation decode; flags default to zero and are set only where meaningful.
  always_comb begin
    o_result        = '0;
    o_flags.carry   = 1'b0;
    o_flags.ovf     = 1'b0;
    o_flags.illegal = 1'b0;
    case (i_op)
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_XOR:   o_result = i_a ^ i_b;
      OP_ADD: begin
        o_result      = w_add[XLEN-1:0];
        o_flags.carry = w_add[XLEN];
        o_flags.ovf   = w_add_ovf;
      end
      OP_SUB: begin
        o_result      = w_sub[XLEN-1:0];
        o_flags.carry = w_sub[XLEN];
        o_flags.ovf   = w_sub_ovf;
      end
      OP_SLL:   o_result = i_a << w_shamt;
      OP_SRL:   o_result = i_a >> w_shamt;
      OP_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
      OP_SLT: begin
        o_result      = {{(XLEN-1){1'b0}}, w_lt_s};
        o_flags.carry = w_sub[XLEN];
      end
      OP_SLTU: begin
        o_result      = {{(XLEN-1){1'b0}}, w_lt_u};
        o_flags.carry = w_sub[XLEN];
      end
      OP_PASSB: o_result = i_b;
      default:  o_flags.illegal = 1'b1;
    endcase
    o_flags.zero = (o_result == '0);
    o_flags.neg  = o_result[MSB];
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready on both sides, flush, and 1- or 2-stage depth.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_result;
  logic [TAG_W-1:0] r_out_tag;
  alu_flags_t       r_out_flags;

  logic             w_en_out;
  logic             w_src_valid;
  logic [XLEN-1:0]  w_core_a;
  logic [XLEN-1:0]  w_core_b;
  logic [3:0]       w_core_op;
  logic [TAG_W-1:0] w_core_tag;
  logic [XLEN-1:0]  w_result;
  alu_flags_t       w_flags;

  assign w_en_out = !r_out_valid || out_ready;

  if (STAGES == 2) begin : g_s1
    logic             r_s1_valid;
    logic [XLEN-1:0]  r_s1_a;
    logic [XLEN-1:0]  r_s1_b;
    logic [3:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic             w_en_s1;

    assign w_en_s1  = !r_s1_valid || w_en_out;
    assign in_ready = w_en_s1 && !flush && !rst;

    // Operand register; data only loads on an accepted operation.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_en_s1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a   <= in_a;
          r_s1_b   <= in_b;
          r_s1_op  <= in_op;
          r_s1_tag <= in_tag;
        end
      end
    end

    assign w_src_valid = r_s1_valid;
    assign w_core_a    = r_s1_a;
    assign w_core_b    = r_s1_b;
    assign w_core_op   = r_s1_op;
    assign w_core_tag  = r_s1_tag;
  end else begin : g_no_s1
    assign in_ready    = w_en_out && !flush && !rst;
    assign w_src_valid = in_valid && in_ready;
    assign w_core_a    = in_a;
    assign w_core_b    = in_b;
    assign w_core_op   = in_op;
    assign w_core_tag  = in_tag;
  end

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_a      (w_core_a),
    .i_b      (w_core_b),
    .i_op     (w_core_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // Output register; rst clears everything, flush only drops the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_flags  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_en_out) begin
      r_out_valid <= w_src_valid;
      if (w_src_valid) begin
        r_out_result <= w_result;
        r_out_tag    <= w_core_tag;
        r_out_flags  <= w_flags;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_tag     = r_out_tag;
  assign out_zero    = r_out_flags.zero;
  assign out_neg     = r_out_flags.neg;
  assign out_carry   = r_out_flags.carry;
  assign out_ovf     = r_out_flags.ovf;
  assign out_illegal = r_out_flags.illegal;

endmodule
